enemy_life_ctrl: RTL and testbench

Per-enemy life and attack controller that sits upstream and downstream of the enemy movement block, one instance per enemy id. It owns enemy hit points and applies bullet hits. It produces the is_alive level consumed by the movement block, runs hurt-flash and respawn timers, and turns the movement block's Enemy_Attack_Ready into rate-limited player-damage pulses. All timers advance only on game_frame_clk_rising_edge.

---
 rtl/boxhead_pkg.sv | 10 +
 rtl/frame_countdown.sv | 21 ++
 rtl/enemy_life_ctrl.sv | 93 +++++++++
 tb/tb_enemy_life_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/boxhead_pkg.sv
// boxhead_pkg: shared life-state type and enemy tuning constants
// Also reused by the player-health block, so the names stay game-wide.
package boxhead_pkg;
  typedef enum logic [1:0] {ALIVE, HURT, DEAD} life_state_t;
  localparam int ENEMY_MAX_HP          = 20;
  localparam int ENEMY_HURT_FRAMES     = 8;
  localparam int ENEMY_RESPAWN_FRAMES  = 180;
  localparam int ENEMY_ATTACK_COOLDOWN = 60;
  localparam int ENEMY_ATTACK_DAMAGE   = 2;
endpackage

// File: rtl/frame_countdown.sv
// frame_countdown: 8-bit frame-paced down-counter with load priority
// Ports: clk_i/rst_i clock and sync reset; load_i/load_val_i reload;
// tick_i decrement enable (stops at zero); last_o count==1; zero_o count==0.
module frame_countdown (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       tick_i,
  output logic       last_o,
  output logic       zero_o
);
  logic [7:0] count_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= 8'd0;
    else if (load_i) count_q <= load_val_i;
    else if (tick_i && count_q != 8'd0) count_q <= count_q - 8'd1;
  end
  assign last_o = count_q == 8'd1;
  assign zero_o = count_q == 8'd0;
endmodule

// File: rtl/enemy_life_ctrl.sv
// enemy_life_ctrl: per-enemy hit points, hurt/respawn timers and rate-limited attacks
// Ports: Clk/Reset; game_frame_clk_rising_edge frame strobe; Bullet_Hit/Bullet_Damage
// incoming hit; Enemy_Attack_Ready from movement; is_alive, Enemy_HP, Is_Hurt levels;
// Player_Damage_Pulse/Damage_Amount attack; Kill_Pulse and Respawn_Pulse events.
module enemy_life_ctrl
  import boxhead_pkg::*;
#(
  parameter int MAX_HP                 = ENEMY_MAX_HP,
  parameter int HURT_FRAMES            = ENEMY_HURT_FRAMES,
  parameter int RESPAWN_FRAMES         = ENEMY_RESPAWN_FRAMES,
  parameter int ATTACK_COOLDOWN_FRAMES = ENEMY_ATTACK_COOLDOWN,
  parameter int ATTACK_DAMAGE          = ENEMY_ATTACK_DAMAGE
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       game_frame_clk_rising_edge,
  input  logic       Bullet_Hit,
  input  logic [3:0] Bullet_Damage,
  input  logic       Enemy_Attack_Ready,
  output logic       is_alive,
  output logic [7:0] Enemy_HP,
  output logic       Is_Hurt,
  output logic       Player_Damage_Pulse,
  output logic [3:0] Damage_Amount,
  output logic       Kill_Pulse,
  output logic       Respawn_Pulse
);
  if (MAX_HP > 255 || HURT_FRAMES > 255 || RESPAWN_FRAMES > 255 ||
      ATTACK_COOLDOWN_FRAMES > 255 || ATTACK_DAMAGE > 15) begin : g_param_check
    $error("enemy_life_ctrl: parameter out of range");
  end
  life_state_t state_q, state_d;
  logic [7:0]  hp_q, hp_d;
  logic        alive_q, hurt_q, kill_q, resp_q, atk_q;
  logic        frame, hit_ok, lethal, soft_hit, hurt_done, revive, attack;
  logic        hurt_last, hurt_zero, resp_last, resp_zero, cd_last, cd_zero;
  logic        unused_flags;
  assign frame = game_frame_clk_rising_edge;
  always_comb begin
    hit_ok    = Bullet_Hit && state_q != DEAD;
    // 9-bit compare so a big bullet never wraps HP; zero damage is never lethal
    lethal    = hit_ok && |Bullet_Damage && {5'd0, Bullet_Damage} >= {1'b0, hp_q};
    soft_hit  = hit_ok && !lethal;
    hurt_done = frame && state_q == HURT && hurt_last && !soft_hit;
    revive    = frame && state_q == DEAD && resp_last;
    // a kill on the same edge suppresses the attack
    attack    = frame && state_q != DEAD && !lethal && Enemy_Attack_Ready && cd_zero;
    state_d   = lethal ? DEAD : soft_hit ? HURT : (hurt_done || revive) ? ALIVE : state_q;
    hp_d      = lethal ? 8'd0 : soft_hit ? hp_q - {4'd0, Bullet_Damage} :
                revive ? 8'(MAX_HP) : hp_q;
  end
  frame_countdown u_hurt (
    .clk_i(Clk), .rst_i(Reset), .load_i(soft_hit), .load_val_i(8'(HURT_FRAMES)),
    .tick_i(frame && state_q == HURT), .last_o(hurt_last), .zero_o(hurt_zero)
  );
  frame_countdown u_respawn (
    .clk_i(Clk), .rst_i(Reset), .load_i(lethal), .load_val_i(8'(RESPAWN_FRAMES)),
    .tick_i(frame && state_q == DEAD), .last_o(resp_last), .zero_o(resp_zero)
  );
  // reloaded on revival too, so a freshly spawned enemy cannot strike at once
  frame_countdown u_cooldown (
    .clk_i(Clk), .rst_i(Reset), .load_i(attack || revive),
    .load_val_i(8'(ATTACK_COOLDOWN_FRAMES)),
    .tick_i(frame && state_q != DEAD && !lethal), .last_o(cd_last), .zero_o(cd_zero)
  );
  assign unused_flags = &{1'b0, hurt_zero, resp_zero, cd_last};
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ALIVE;
      hp_q    <= 8'(MAX_HP);
      alive_q <= 1'b1;
      hurt_q  <= 1'b0;
      kill_q  <= 1'b0;
      resp_q  <= 1'b0;
      atk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      alive_q <= state_d != DEAD;
      hurt_q  <= state_d == HURT;
      kill_q  <= lethal;
      resp_q  <= revive;
      atk_q   <= attack;
    end
  end
  assign is_alive            = alive_q;
  assign Enemy_HP            = hp_q;
  assign Is_Hurt             = hurt_q;
  assign Player_Damage_Pulse = atk_q;
  assign Damage_Amount       = 4'(ATTACK_DAMAGE);
  assign Kill_Pulse          = kill_q;
  assign Respawn_Pulse       = resp_q;
endmodule

// File: tb/tb_enemy_life_ctrl.sv
// tb_enemy_life_ctrl: directed scenarios plus random stimulus against a frames-remaining model
module tb_enemy_life_ctrl;
  logic       Clk = 1'b0, Reset = 1'b1, frame = 1'b0, hit = 1'b0, ready = 1'b0;
  logic [3:0] dmg = 4'd0;
  logic       is_alive, Is_Hurt, atk, Kill_Pulse, Respawn_Pulse;
  logic [7:0] Enemy_HP;
  logic [3:0] Damage_Amount;
  int checks = 0, errors = 0;
  bit m_dead, m_hurt, m_kill, m_resp, m_atk;
  int m_hp, m_hurt_left, m_dead_left, m_cd;

  enemy_life_ctrl dut (
    .Clk(Clk), .Reset(Reset), .game_frame_clk_rising_edge(frame), .Bullet_Hit(hit),
    .Bullet_Damage(dmg), .Enemy_Attack_Ready(ready), .is_alive(is_alive),
    .Enemy_HP(Enemy_HP), .Is_Hurt(Is_Hurt), .Player_Damage_Pulse(atk),
    .Damage_Amount(Damage_Amount), .Kill_Pulse(Kill_Pulse), .Respawn_Pulse(Respawn_Pulse)
  );

  always #10 Clk = ~Clk;

  task automatic cyc(input bit r, input bit f, input bit h, input int d, input bit rdy);
    @(negedge Clk);
    Reset = r; frame = f; hit = h; dmg = 4'(d); ready = rdy;
    @(posedge Clk);
    m_kill = 0; m_resp = 0; m_atk = 0;
    if (r) begin
      m_dead = 0; m_hurt = 0; m_hp = 20; m_hurt_left = 0; m_dead_left = 0; m_cd = 0;
    end else if (m_dead) begin
      if (f) begin
        m_dead_left--;
        if (m_dead_left == 0) begin m_dead = 0; m_hp = 20; m_resp = 1; m_cd = 60; end
      end
    end else begin
      if (h && d > 0 && d >= m_hp) begin
        m_dead = 1; m_hurt = 0; m_hp = 0; m_kill = 1; m_dead_left = 180;
      end else if (h) begin
        m_hp -= d; m_hurt = 1; m_hurt_left = 8;
      end else if (m_hurt && f) begin
        m_hurt_left--;
        if (m_hurt_left == 0) m_hurt = 0;
      end
      if (f && !m_kill) begin
        if (rdy && m_cd == 0) begin m_atk = 1; m_cd = 60; end
        else if (m_cd > 0) m_cd--;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0);
    checks++; if (is_alive !== 1'b1) begin errors++; $display("FAIL reset_alive got %0b want 1", is_alive); end
    checks++; if (Enemy_HP !== 8'd20) begin errors++; $display("FAIL reset_hp got %0d want 20", Enemy_HP); end
    checks++; if (Is_Hurt !== 1'b0) begin errors++; $display("FAIL reset_hurt got %0b want 0", Is_Hurt); end
    checks++; if (Damage_Amount !== 4'd2) begin errors++; $display("FAIL damage_amount got %0d want 2", Damage_Amount); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0);
      checks++;
      if ({is_alive, Enemy_HP, Is_Hurt, atk, Kill_Pulse, Respawn_Pulse} !== {1'b1, 8'd20, 4'b0000}) begin
        errors++;
        $display("FAIL idle_frame%0d got alive=%0b hp=%0d hurt=%0b atk=%0b kill=%0b resp=%0b want 1/20/0/0/0/0",
                 i, is_alive, Enemy_HP, Is_Hurt, atk, Kill_Pulse, Respawn_Pulse);
      end
    end
  endtask

  task automatic test_hurt();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 5, 0);
    checks++; if (Enemy_HP !== 8'd15) begin errors++; $display("FAIL hit5_hp got %0d want 15", Enemy_HP); end
    checks++; if (Is_Hurt !== 1'b1) begin errors++; $display("FAIL hit5_hurt got %0b want 1", Is_Hurt); end
    for (int i = 0; i < 3; i++) begin cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0); end
    cyc(0, 1, 1, 5, 0);
    checks++; if (Enemy_HP !== 8'd10) begin errors++; $display("FAIL rehit_hp got %0d want 10", Enemy_HP); end
    for (int i = 1; i <= 7; i++) begin
      cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
      checks++; if (Is_Hurt !== 1'b1) begin errors++; $display("FAIL reload_hurt_f%0d got %0b want 1", i, Is_Hurt); end
    end
    cyc(0, 1, 0, 0, 0);
    checks++; if (Is_Hurt !== 1'b0) begin errors++; $display("FAIL hurt_expire got %0b want 0", Is_Hurt); end
    checks++; if (is_alive !== 1'b1) begin errors++; $display("FAIL hurt_alive got %0b want 1", is_alive); end
  endtask

  task automatic test_kill_respawn();
    int resp_seen = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 15, 0);
    cyc(0, 0, 1, 6, 0);
    checks++; if ({Enemy_HP, is_alive, Kill_Pulse} !== {8'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL kill got hp=%0d alive=%0b kill=%0b want 0/0/1", Enemy_HP, is_alive, Kill_Pulse); end
    cyc(0, 0, 1, 9, 0);
    checks++; if ({Enemy_HP, Kill_Pulse, Is_Hurt} !== {8'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL dead_hit got hp=%0d kill=%0b hurt=%0b want 0/0/0", Enemy_HP, Kill_Pulse, Is_Hurt); end
    for (int i = 0; i < 179; i++) begin
      cyc(0, 1, 0, 0, 0); resp_seen += Respawn_Pulse;
      cyc(0, 0, 0, 0, 0); resp_seen += Respawn_Pulse;
    end
    checks++; if (is_alive !== 1'b0 || resp_seen != 0) begin
      errors++; $display("FAIL early_respawn got alive=%0b pulses=%0d want 0/0", is_alive, resp_seen); end
    cyc(0, 1, 0, 0, 0);
    checks++; if ({is_alive, Enemy_HP, Respawn_Pulse} !== {1'b1, 8'd20, 1'b1}) begin
      errors++; $display("FAIL respawn got alive=%0b hp=%0d resp=%0b want 1/20/1", is_alive, Enemy_HP, Respawn_Pulse); end
    cyc(0, 0, 0, 0, 0);
    checks++; if (Respawn_Pulse !== 1'b0) begin errors++; $display("FAIL respawn_width got %0b want 0", Respawn_Pulse); end
  endtask

  task automatic test_attack_rate();
    int got[$];
    int exp_edges[4] = '{1, 62, 123, 184};
    int stray = 0;
    cyc(1, 0, 0, 0, 0);
    for (int n = 1; n <= 200; n++) begin
      cyc(0, 1, 0, 0, 1);
      if (atk === 1'b1) got.push_back(n);
      cyc(0, 0, 0, 0, 1);
      if (atk !== 1'b0) stray++;
    end
    checks++; if (got.size() != 4 || stray != 0) begin
      errors++; $display("FAIL attack_count got %0d pulses (%0d stray) want 4/0", got.size(), stray); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (k >= got.size() || got[k] != exp_edges[k]) begin
        errors++; $display("FAIL attack_edge%0d got %0d want %0d", k, (k < got.size()) ? got[k] : -1, exp_edges[k]); end
    end
  endtask

  task automatic test_kill_vs_attack();
    int atk_seen = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 10, 0);
    cyc(0, 1, 1, 15, 1);
    checks++; if ({Kill_Pulse, atk, is_alive} !== {1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL kill_vs_attack got kill=%0b atk=%0b alive=%0b want 1/0/0", Kill_Pulse, atk, is_alive); end
    for (int i = 0; i < 180; i++) begin cyc(0, 1, 0, 0, 1); atk_seen += atk; cyc(0, 0, 0, 0, 1); atk_seen += atk; end
    checks++; if (is_alive !== 1'b1 || atk_seen != 0) begin
      errors++; $display("FAIL dead_attack got alive=%0b pulses=%0d want 1/0", is_alive, atk_seen); end
    for (int i = 0; i < 60; i++) begin cyc(0, 1, 0, 0, 1); atk_seen += atk; cyc(0, 0, 0, 0, 1); atk_seen += atk; end
    checks++; if (atk_seen != 0) begin errors++; $display("FAIL revive_cooldown got %0d pulses want 0", atk_seen); end
    cyc(0, 1, 0, 0, 1);
    checks++; if (atk !== 1'b1) begin errors++; $display("FAIL revive_first_attack got %0b want 1", atk); end
  endtask

  task automatic test_reset_dead();
    int resp_seen = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 15, 0);
    cyc(0, 0, 1, 6, 0);
    for (int i = 0; i < 130; i++) begin cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0); end
    cyc(1, 1, 0, 0, 0);
    checks++; if ({is_alive, Enemy_HP, Is_Hurt, Respawn_Pulse, Kill_Pulse} !== {1'b1, 8'd20, 3'b000}) begin
      errors++; $display("FAIL reset_in_dead got alive=%0b hp=%0d hurt=%0b resp=%0b kill=%0b want 1/20/0/0/0",
                         is_alive, Enemy_HP, Is_Hurt, Respawn_Pulse, Kill_Pulse); end
    for (int i = 0; i < 60; i++) begin cyc(0, 1, 0, 0, 0); resp_seen += Respawn_Pulse; end
    checks++; if (resp_seen != 0 || is_alive !== 1'b1) begin
      errors++; $display("FAIL stale_respawn got pulses=%0d alive=%0b want 0/1", resp_seen, is_alive); end
  endtask

  task automatic test_random();
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 6000; i++) begin
      cyc($urandom_range(0, 999) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
          int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      checks++;
      if ({is_alive, Enemy_HP, Is_Hurt, atk, Kill_Pulse, Respawn_Pulse} !==
          {!m_dead, 8'(m_hp), m_hurt, m_atk, m_kill, m_resp}) begin
        errors++;
        $display("FAIL random_cycle%0d got alive=%0b hp=%0d hurt=%0b atk=%0b kill=%0b resp=%0b want %0b/%0d/%0b/%0b/%0b/%0b",
                 i, is_alive, Enemy_HP, Is_Hurt, atk, Kill_Pulse, Respawn_Pulse,
                 !m_dead, m_hp, m_hurt, m_atk, m_kill, m_resp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hurt();
    test_kill_respawn();
    test_attack_rate();
    test_kill_vs_attack();
    test_reset_dead();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
